// File: rtl/pingpong_tx_if.sv
// rtl/pingpong_tx_if.sv - producer and drain signal bundle for pingpong_tx
//
// Fill side  : wr_en, wa[2:0], di[63:0], be[7:0], commit, len[2:0] -> DUT;
//              wr_ready, ovf_err <- DUT
// Drain side : dout[63:0], dout_valid, dout_last <- DUT; dout_ready -> DUT
// master = producer/consumer environment, slave = pingpong_tx.
interface pingpong_tx_if;
  logic        wr_en;
  logic [2:0]  wa;
  logic [63:0] di;
  logic [7:0]  be;
  logic        commit;
  logic [2:0]  len;
  logic        wr_ready;
  logic [63:0] dout;
  logic        dout_valid;
  logic        dout_last;
  logic        dout_ready;
  logic        ovf_err;

  modport master (
    output wr_en, wa, di, be, commit, len, dout_ready,
    input  wr_ready, dout, dout_valid, dout_last, ovf_err
  );

  modport slave (
    input  wr_en, wa, di, be, commit, len, dout_ready,
    output wr_ready, dout, dout_valid, dout_last, ovf_err
  );
endinterface

// File: rtl/pingpong_tx.sv
// rtl/pingpong_tx.sv - outbound two-bank (ping-pong) 8 x 64-bit transmit buffer
//
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : pingpong_tx_if.slave
//           fill  - byte-enabled writes into the current fill bank, commit
//                   hands it to the drain side with its last word index
//           drain - streams committed banks word by word (valid/ready),
//                   dout_last on the bank's last word
//           ovf_err is sticky once a write/commit hits a busy fill bank
module pingpong_tx (
  input  logic          clk,
  input  logic          rst_n,
  pingpong_tx_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       full_q, full_d;
  logic [1:0][2:0]  len_q, len_d;
  logic             fill_sel_q, fill_sel_d;
  logic             drain_sel_q, drain_sel_d;
  logic [2:0]       rd_addr_q, rd_addr_d;
  logic [63:0]      dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             dout_last_q, dout_last_d;
  logic             ovf_err_q, ovf_err_d;

  // Storage is not reset; content after reset is whatever was left behind.
  logic [63:0]      mem_q [2][8];

  logic             wr_ready;
  logic             wr_acc;

  assign wr_ready = ~full_q[fill_sel_q];
  assign wr_acc   = bus.wr_en & wr_ready;

  always_comb begin
    state_d      = state_q;
    full_d       = full_q;
    len_d        = len_q;
    fill_sel_d   = fill_sel_q;
    drain_sel_d  = drain_sel_q;
    rd_addr_d    = rd_addr_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    dout_last_d  = dout_last_q;
    ovf_err_d    = ovf_err_q;

    if ((bus.wr_en | bus.commit) & ~wr_ready) begin
      ovf_err_d = 1'b1;
    end

    if (bus.commit & wr_ready) begin
      full_d[fill_sel_q] = 1'b1;
      len_d[fill_sel_q]  = bus.len;
      fill_sel_d         = ~fill_sel_q;
    end

    // A release never targets the bank being committed: commit needs the
    // fill bank empty, release needs the drain bank full.
    unique case (state_q)
      ST_IDLE: begin
        dout_valid_d = 1'b0;
        if (full_q[drain_sel_q]) begin
          rd_addr_d = 3'd0;
          state_d   = ST_FETCH;
        end
      end
      ST_FETCH: begin
        dout_d       = mem_q[drain_sel_q][rd_addr_q];
        dout_last_d  = (rd_addr_q == len_q[drain_sel_q]);
        dout_valid_d = 1'b1;
        state_d      = ST_SEND;
      end
      ST_SEND: begin
        if (bus.dout_ready) begin
          dout_valid_d = 1'b0;
          if (dout_last_q) begin
            full_d[drain_sel_q] = 1'b0;
            drain_sel_d         = ~drain_sel_q;
            state_d             = ST_IDLE;
          end else begin
            rd_addr_d = rd_addr_q + 3'd1;
            state_d   = ST_FETCH;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      full_q       <= 2'b00;
      len_q        <= '0;
      fill_sel_q   <= 1'b0;
      drain_sel_q  <= 1'b0;
      rd_addr_q    <= 3'd0;
      dout_q       <= 64'd0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      ovf_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      full_q       <= full_d;
      len_q        <= len_d;
      fill_sel_q   <= fill_sel_d;
      drain_sel_q  <= drain_sel_d;
      rd_addr_q    <= rd_addr_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_last_q  <= dout_last_d;
      ovf_err_q    <= ovf_err_d;
    end
  end

  // A write in the commit cycle still targets the pre-commit fill_sel_q,
  // so it lands in the bank being committed.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int i = 0; i < 8; i++) begin
        if (bus.be[i]) begin
          mem_q[fill_sel_q][bus.wa][8*i +: 8] <= bus.di[8*i +: 8];
        end
      end
    end
  end

  assign bus.wr_ready   = wr_ready;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.dout_last  = dout_last_q;
  assign bus.ovf_err    = ovf_err_q;

endmodule

// File: tb/tb_pingpong_tx.sv
// tb/tb_pingpong_tx.sv - scoreboard bench for pingpong_tx
module tb_pingpong_tx;

  logic clk;
  logic rst_n;

  pingpong_tx_if bus ();

  pingpong_tx dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [63:0] mask;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] m_mem   [2][8];
  logic [7:0]  m_known [2][8];
  int          pending;
  int          m_fill;
  bit          m_ovf;
  bit          rel_flag;
  bit          ok;

  int          n_checks;
  int          n_fail;
  int          n_acc;
  logic [63:0] last_acc;
  bit          prev_hold;
  logic [63:0] prev_dout;
  logic        prev_last;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: two banks, a count of committed-but-unreleased banks,
  // and the list of words each commit will eventually put on the wire.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  = 0;
      m_fill   = 0;
      m_ovf    = 0;
      rel_flag = 0;
      exp_q.delete();
      for (int b = 0; b < 2; b++)
        for (int w = 0; w < 8; w++) m_known[b][w] = 8'h00;
    end else begin
      ok = (pending < 2);
      if (bus.wr_en) begin
        if (ok) begin
          for (int i = 0; i < 8; i++) begin
            if (bus.be[i]) begin
              m_mem[m_fill][bus.wa][8*i +: 8] = bus.di[8*i +: 8];
              m_known[m_fill][bus.wa][i] = 1'b1;
            end
          end
        end else m_ovf = 1;
      end
      if (bus.commit) begin
        if (ok) begin
          for (int w = 0; w <= int'(bus.len); w++) begin
            exp_t e;
            e.data = m_mem[m_fill][w];
            for (int i = 0; i < 8; i++) e.mask[8*i +: 8] = {8{m_known[m_fill][w][i]}};
            e.last = (w == int'(bus.len));
            exp_q.push_back(e);
          end
          pending++;
          m_fill ^= 1;
        end else m_ovf = 1;
      end
      if (rel_flag) begin
        pending--;
        rel_flag = 0;
      end
    end
  end

  // Monitor: samples just after each falling edge; a valid&ready seen here
  // is the transfer that completes at the next rising edge.
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      check("rst_dout_valid", bus.dout_valid, 0);
      check("rst_dout", bus.dout, 64'd0);
      check("rst_dout_last", bus.dout_last, 0);
      check("rst_ovf_err", bus.ovf_err, 0);
      check("rst_wr_ready", bus.wr_ready, 1);
      prev_hold = 0;
    end else begin
      check("wr_ready", bus.wr_ready, (pending < 2));
      check("ovf_err", bus.ovf_err, m_ovf);
      if (prev_hold) begin
        check("hold_valid", bus.dout_valid, 1);
        check("hold_dout", bus.dout, prev_dout);
        check("hold_last", bus.dout_last, prev_last);
      end
      prev_hold = 0;
      if (bus.dout_valid === 1'b1) begin
        if (bus.dout_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_word", bus.dout, 64'hx);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("dout", bus.dout & e.mask, e.data & e.mask);
            check("dout_last", bus.dout_last, e.last);
            if (e.last) rel_flag = 1;
          end
          n_acc++;
          last_acc = bus.dout;
        end else begin
          prev_hold = 1;
          prev_dout = bus.dout;
          prev_last = bus.dout_last;
        end
      end
    end
  end

  task automatic step(input logic w, input logic [2:0] a, input logic [63:0] d,
                      input logic [7:0] b, input logic c, input logic [2:0] l);
    @(negedge clk);
    bus.wr_en  = w;
    bus.wa     = a;
    bus.di     = d;
    bus.be     = b;
    bus.commit = c;
    bus.len    = l;
  endtask

  task automatic idle();
    step(1'b0, 3'd0, 64'd0, 8'h00, 1'b0, 3'd0);
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    idle();
    bus.dout_ready = 1'b1;
    while ((exp_q.size() != 0 || pending != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(nm, (exp_q.size() == 0 && pending == 0), 1);
  endtask

  task automatic wait_acc(input int target, input string nm);
    int n;
    n = 0;
    while (n_acc != target && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(nm, (n_acc == target), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [63:0] nw;
    n_checks = 0; n_fail = 0; n_acc = 0; prev_hold = 0; last_acc = '0;
    bus.wr_en = 0; bus.wa = 0; bus.di = 0; bus.be = 0;
    bus.commit = 0; bus.len = 0; bus.dout_ready = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Basic: 8 words, commit-to-valid latency of two edges.
    bus.dout_ready = 1'b1;
    for (int k = 0; k < 8; k++) step(1, 3'(k), 64'h1111_0000_0000_0000 | 64'(k), 8'hFF, 0, 0);
    step(0, 0, 0, 0, 1, 3'd7);
    idle();
    #1 check("lat_after_k", bus.dout_valid, 0);
    @(negedge clk); #1 check("lat_after_k1", bus.dout_valid, 0);
    @(negedge clk); #1 check("lat_after_k2", bus.dout_valid, 1);
    base = n_acc - 0;
    wait_drain("basic_drain");
    check("basic_last_word", last_acc, 64'h1111_0000_0000_0007);

    // Byte enables.
    step(1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 0);
    step(1, 0, 64'h0, 8'h0F, 0, 0);
    step(0, 0, 0, 0, 1, 3'd0);
    wait_drain("be_drain");
    check("be_word", last_acc, 64'hFFFF_FFFF_0000_0000);

    // Backpressure on word 1.
    for (int k = 0; k < 4; k++) step(1, 3'(k), {$urandom, $urandom}, 8'hFF, 0, 0);
    base = n_acc;
    step(0, 0, 0, 0, 1, 3'd3);
    idle();
    wait_acc(base + 1, "bp_word0");
    bus.dout_ready = 1'b0;
    repeat (5) @(negedge clk);
    bus.dout_ready = 1'b1;
    wait_drain("bp_drain");
    check("bp_count", n_acc - base, 4);

    // Ping-pong with both banks full, then overflow attempts.
    bus.dout_ready = 1'b0;
    for (int k = 0; k < 8; k++) step(1, 3'(k), {$urandom, $urandom}, 8'hFF, 0, 0);
    step(0, 0, 0, 0, 1, 3'd7);
    for (int k = 0; k < 8; k++) step(1, 3'(k), {$urandom, $urandom}, 8'hFF, 0, 0);
    step(0, 0, 0, 0, 1, 3'd7);
    idle();
    step(1, 3'd1, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 0, 0);
    step(0, 0, 0, 0, 1, 3'd2);
    idle();
    #1;
    check("ovf_set", bus.ovf_err, 1);
    check("ovf_wr_ready_low", bus.wr_ready, 0);
    base = n_acc;
    wait_drain("ovf_drain");
    check("ovf_count", n_acc - base, 16);

    // Write and commit in the same cycle.
    for (int k = 0; k < 3; k++) step(1, 3'(k), 64'h2222_0000_0000_0000 | 64'(k), 8'hFF, 0, 0);
    nw = 64'hA5A5_5A5A_0123_4567;
    step(1, 3'd2, nw, 8'hFF, 1, 3'd2);
    wait_drain("wc_drain");
    check("wc_word2", last_acc, 64'hA5A5_5A5A_0123_4567);

    // Random traffic.
    repeat (300) begin
      @(negedge clk);
      bus.wr_en      = ($urandom_range(0, 1) == 1);
      bus.wa         = 3'($urandom_range(0, 7));
      bus.di         = {$urandom, $urandom};
      bus.be         = 8'($urandom_range(0, 255));
      bus.commit     = ($urandom_range(0, 7) == 0);
      bus.len        = 3'($urandom_range(0, 7));
      bus.dout_ready = ($urandom_range(0, 9) < 7);
    end
    wait_drain("rand_drain");

    // Reset during SEND of word 3.
    for (int k = 0; k < 8; k++) step(1, 3'(k), {$urandom, $urandom}, 8'hFF, 0, 0);
    base = n_acc;
    step(0, 0, 0, 0, 1, 3'd7);
    idle();
    wait_acc(base + 3, "rst_reach_word3");
    bus.dout_ready = 1'b0;
    @(negedge clk);
    check("rst_pre_valid", bus.dout_valid, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", bus.dout_valid, 0);
    check("rst_mid_wr_ready", bus.wr_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) step(1, 3'(k), 64'h3333_0000_0000_0000 | 64'(k), 8'hFF, 0, 0);
    base = n_acc;
    step(0, 0, 0, 0, 1, 3'd3);
    wait_drain("post_rst_drain");
    check("post_rst_count", n_acc - base, 4);
    check("post_rst_last", last_acc, 64'h3333_0000_0000_0003);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
